fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Read-side engine for the team's synchronous FIFO. It drives the FIFO's rd_en/dout/empty interface and presents the data as a valid/ready stream to a downstream consumer. The FIFO has a registered read, so dout is valid one cycle after rd_en. This block tracks that in-flight read and absorbs it in a small skid buffer, so consumer backpressure never drops data. It sits between the FIFO instance and any streaming sink, such as a serializer or packetizer.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
BUF_DEPTH, 2, skid buffer entries; legal values 2 or 4 (power of two, minimum 2 for full throughput)
CNT_WIDTH, 16, width of the accepted-beat counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  permit new FIFO reads; data already fetched still drains when low
fifo_rd_en  output  1  read strobe to FIFO
fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  stream data valid
m_ready  input  1  consumer ready
m_data  output  DATA_WIDTH  stream data
xfer_count  output  CNT_WIDTH  number of accepted beats (m_valid && m_ready)
idle  output  1  high when no read is in flight and the buffer is empty

Behaviour:
- One clock domain; clk is the only clock. Reset is asynchronous and active-low.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, xfer_count=0, idle=1. Buffer pointers, occupancy (occ) and the inflight flag are all cleared.
- pop = m_valid && m_ready. Pop is a combinational term of m_ready.
- fifo_rd_en = rst_n && en && !fifo_empty && ((occ + inflight - pop) < BUF_DEPTH).
  - At most one read is issued per cycle.
  - m_ready reaches fifo_rd_en combinationally; this path is accepted.
- inflight register: on each rising edge, inflight <= fifo_rd_en.
- Capture: when inflight=1, fifo_dout is written to the buffer tail on that edge.
  - Capture is unconditional. The credit rule guarantees a free slot.
  - A capture with occ==BUF_DEPTH and no pop is a design error; flag it with an assertion.
- Buffer:
  - Circular store with head/tail pointers that wrap modulo BUF_DEPTH. occ is in 0..BUF_DEPTH.
  - Capture and pop in the same cycle leave occ unchanged.
- m_valid = (occ != 0). m_data = entry at head.
  - Both are driven from registers or buffer storage, with no combinational path from m_ready.
  - m_data stays stable while m_valid && !m_ready.
- Latency and throughput:
  - The first word appears on m_valid 2 cycles after fifo_rd_en is sampled: read edge, then capture edge.
  - Steady state is 1 beat per cycle when m_ready is held high.
- Ordering: strict FIFO order; no data is lost or duplicated.
- en low: no new reads are issued. An in-flight word is still captured, and the buffer keeps draining.
- fifo_empty high: no read is issued. The block does not speculate.
- xfer_count increments by 1 on every pop and wraps from all-ones to 0 with no saturation.
- idle = (occ==0) && !inflight.
- Reset mid-operation: all state clears asynchronously and m_valid drops immediately. Any word in flight is discarded. The FIFO is expected to be reset alongside this block.

Test Plan:
1. Stream: FIFO preloaded with A1,A2,A3,A4; en=1, m_ready=1 -> fifo_rd_en high for 4 consecutive cycles; m_valid for 4 consecutive cycles carrying A1..A4, starting 2 cycles after the first rd_en; xfer_count=4; idle=1 afterwards.
2. Backpressure: 8 words queued (B0..B7), m_ready=0 -> exactly BUF_DEPTH (2) rd_en pulses, then rd_en stays low; m_data=B0 stable. Release m_ready -> B0..B7 delivered in order; xfer_count=8.
3. Toggling ready: 16 words, m_ready pattern 1,0,1,0... -> all 16 delivered in order; occ never exceeds 2; no overflow assertion fires; xfer_count=16.
4. Enable drop: deassert en in the same cycle a read is in flight -> that word is still delivered on m_stream; no further fifo_rd_en until en=1; then the stream resumes in order.
5. Empty FIFO: fifo_empty=1 for 20 cycles with en=1 -> fifo_rd_en=0, m_valid=0, idle=1 throughout.
6. Reset mid-run: assert rst_n low with occ=2 and a read in flight -> m_valid, xfer_count and idle go to 0/0/1 without waiting for a clock edge; after release with a fresh preload C0..C2 -> C0..C2 delivered; xfer_count=3.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side engine: turns a registered-read FIFO port into a valid/ready stream.
// Latency: first beat on m_valid two edges after fifo_rd_en is sampled (read edge, capture edge).
// Backpressure: reads are credit-limited so the skid buffer always has room for an in-flight word.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,   // 2 or 4; power of two so pointers wrap naturally
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  idle
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CRD_W = PTR_W + 2;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUF_DEPTH);
  localparam logic [CRD_W-1:0] CRD_LIMIT = CRD_W'(BUF_DEPTH);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  logic                  pop;
  logic                  capture;
  logic [CRD_W-1:0]      credit_need;

  // Stream side comes straight from state so m_ready never reaches m_valid/m_data.
  assign m_valid    = (occ_q != '0);
  assign m_data     = mem_q[head_q];
  assign pop        = m_valid && m_ready;
  assign capture    = inflight_q;
  assign xfer_count = cnt_q;
  assign idle       = (occ_q == '0) && !inflight_q;

  // Slots committed after this edge: stored words plus the in-flight word, minus the beat leaving now.
  assign credit_need = CRD_W'(occ_q) + CRD_W'(inflight_q) - CRD_W'(pop);
  assign fifo_rd_en  = rst_n && en && !fifo_empty && (credit_need < CRD_LIMIT);

  // Next-state for pointers, occupancy, in-flight flag and beat counter.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q;
    if (capture) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d = head_q + PTR_W'(1);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
    case ({capture, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards any word still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // Skid storage: the registered FIFO word lands at the tail whenever a read was issued last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (capture) begin
      mem_q[tail_q] <= fifo_dout;
    end
  end

  // A capture into a full buffer with nothing leaving means the credit rule was broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (occ_q == OCC_FULL) && !pop));

endmodule
